// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx -- parallel-in serial-out frame transmitter
//
// Accepts a WIDTH-bit word over a valid/ready handshake and sends it on a
// single line as: start bit (0), data bits LSB first, stop bit (1). Every
// bit is held for DIV clocks.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   din         parallel word, sampled only on an accepting edge
//   load_valid  producer offers a word on din
//   load_ready  block can accept a word (inverse of busy)
//   sout        registered serial line, idles high
//   busy        registered, high while a frame is in progress
//   done        registered one-clock pulse at frame completion
// ---------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH = 4,   // data bits per frame, 1..16
    parameter int DIV   = 4    // clocks per serial bit, 1..255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       div_cnt_reg, div_cnt_next;
    logic             sout_reg, sout_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             at_boundary;
    logic [WIDTH-1:0] shifted;

    // With DIV=1 DIV_LAST is 0, so every clock is a boundary and the
    // divider wraps to 0 instead of counting.
    assign at_boundary = (div_cnt_reg == DIV_LAST);
    // Shifting through a temporary keeps the "next bit" select legal even
    // when WIDTH is 1.
    assign shifted     = shift_reg >> 1;

    assign load_ready = ~busy_reg;
    assign sout       = sout_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            sout_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            div_cnt_reg <= div_cnt_next;
            sout_reg    <= sout_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        div_cnt_next = div_cnt_reg;
        sout_next    = sout_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        if (state_reg != IDLE) begin
            div_cnt_next = at_boundary ? 8'd0 : div_cnt_reg + 8'd1;
        end

        case (state_reg)
            IDLE: begin
                // The start bit goes out on the accepting edge itself.
                if (load_valid && load_ready) begin
                    shift_next   = din;
                    state_next   = START;
                    busy_next    = 1'b1;
                    sout_next    = 1'b0;
                    div_cnt_next = 8'd0;
                end
            end
            START: begin
                if (at_boundary) begin
                    sout_next    = shift_reg[0];
                    state_next   = DATA;
                    bit_cnt_next = 4'd0;
                end
            end
            DATA: begin
                if (at_boundary) begin
                    if (bit_cnt_reg < BIT_LAST) begin
                        shift_next   = shifted;
                        sout_next    = shifted[0];
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else begin
                        sout_next  = 1'b1;
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (at_boundary) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx -- bench for piso_tx
//
// Two instances share clock and reset: u4 (WIDTH=4, DIV=4) and u8
// (WIDTH=8, DIV=1). Each frame sent pushes its expected per-clock line
// values into a queue; a monitor pops one value per busy clock and compares
// it with sout, checks the idle line, and checks frame length at done.
// ---------------------------------------------------------------------------
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] din4 = '0;
    logic [7:0] din8 = '0;
    logic       lv4 = 1'b0, lv8 = 1'b0;
    logic       rdy4, rdy8, sout4, sout8, busy4, busy8, done4, done8;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  done_cnt4 = 0, done_cnt8 = 0;
    int  bc4 = 0, bc8 = 0;
    bit  q4[$];
    bit  q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_tx #(.WIDTH(4), .DIV(4)) u4 (
        .clk(clk), .reset(reset), .din(din4), .load_valid(lv4),
        .load_ready(rdy4), .sout(sout4), .busy(busy4), .done(done4)
    );

    piso_tx #(.WIDTH(8), .DIV(1)) u8 (
        .clk(clk), .reset(reset), .din(din8), .load_valid(lv8),
        .load_ready(rdy8), .sout(sout8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Expected line, one entry per clock: start, data LSB first, stop.
    task automatic push4(input logic [3:0] d);
        logic [5:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int b = 0; b < 6; b++)
            for (int k = 0; k < 4; k++) q4.push_back(fr[b]);
    endtask

    task automatic push8(input logic [7:0] d);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int b = 0; b < 10; b++) q8.push_back(fr[b]);
    endtask

    // Monitors
    initial forever begin
        @(negedge clk);
        if (reset !== 1'b0) begin
            bc4 = 0;
        end else begin
            if (busy4 === 1'b1) begin
                bc4++;
                if (q4.size() == 0) check("u4_extra_busy", 1, 0);
                else check("u4_sout", sout4, q4.pop_front());
            end else begin
                check("u4_idle_line", sout4, 1);
            end
            if (done4 === 1'b1) begin
                done_cnt4++;
                check("u4_frame_len", bc4, 24);
                check("u4_ready_at_done", rdy4, 1);
                bc4 = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset !== 1'b0) begin
            bc8 = 0;
        end else begin
            if (busy8 === 1'b1) begin
                bc8++;
                if (q8.size() == 0) check("u8_extra_busy", 1, 0);
                else check("u8_sout", sout8, q8.pop_front());
            end else begin
                check("u8_idle_line", sout8, 1);
            end
            if (done8 === 1'b1) begin
                done_cnt8++;
                check("u8_frame_len", bc8, 10);
                bc8 = 0;
            end
        end
    end

    task automatic wait_done(input bit sel, output int t);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel ? done8 : done4) === 1'b1) begin
                t = cyc;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic send4(input logic [3:0] d);
        @(negedge clk);
        din4 = d; lv4 = 1'b1; push4(d);
        @(negedge clk);
        lv4 = 1'b0;
    endtask

    initial begin
        int t1, t2, dc;

        // Reset values appear before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_sout", sout4, 1);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_ready", rdy4, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame 4'b1010
        dc = done_cnt4;
        send4(4'b1010);
        din4 = 4'hC;               // mid-frame din change must not matter
        wait_done(0, t1);
        @(negedge clk);
        check("single_done_cnt", done_cnt4 - dc, 1);
        check("single_q_empty", q4.size(), 0);
        $display("frame 4'hA sent, done at cycle %0d", t1);

        // Back-to-back, load_valid held: 4'hF then 4'h0
        dc = done_cnt4;
        @(negedge clk);
        din4 = 4'hF; lv4 = 1'b1; push4(4'hF); push4(4'h0);
        @(negedge clk);
        din4 = 4'h0;
        wait_done(0, t1);
        @(negedge clk);
        check("b2b_accept", busy4, 1);
        lv4 = 1'b0;
        wait_done(0, t2);
        check("b2b_done_gap", t2 - t1, 25);
        repeat (30) @(negedge clk);
        check("b2b_done_cnt", done_cnt4 - dc, 2);
        check("b2b_q_empty", q4.size(), 0);
        $display("back-to-back frames 4'hF,4'h0, done gap %0d", t2 - t1);

        // Ignore load while busy
        dc = done_cnt4;
        send4(4'h3);
        repeat (8) @(negedge clk);
        din4 = 4'h5; lv4 = 1'b1;
        @(negedge clk);
        lv4 = 1'b0;
        wait_done(0, t1);
        repeat (40) @(negedge clk);
        check("busy_ignore_done_cnt", done_cnt4 - dc, 1);
        check("busy_ignore_q_empty", q4.size(), 0);
        $display("frame 4'h3 with ignored load of 4'h5");

        // Reset mid-frame
        dc = done_cnt4;
        send4(4'hA);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_sout", sout4, 1);
        check("midrst_busy", busy4, 0);
        check("midrst_ready", rdy4, 1);
        q4.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt4 - dc, 0);
        send4(4'h6);
        wait_done(0, t1);
        @(negedge clk);
        check("after_rst_done_cnt", done_cnt4 - dc, 1);
        check("after_rst_q_empty", q4.size(), 0);
        $display("frame 4'hA aborted by reset, frame 4'h6 sent");

        // DIV=1, WIDTH=8
        dc = done_cnt8;
        @(negedge clk);
        din8 = 8'h81; lv8 = 1'b1; push8(8'h81);
        @(negedge clk);
        lv8 = 1'b0;
        t1 = cyc;
        wait_done(1, t2);
        check("div1_done_clock", t2 - t1, 10);
        @(negedge clk);
        check("div1_done_cnt", done_cnt8 - dc, 1);
        check("div1_q_empty", q8.size(), 0);
        $display("frame 8'h81 at DIV=1, done %0d clocks after accept", t2 - t1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
